// File: rtl/mac_pkg.sv
// Shared constants and FSM state encoding for the systolic MAC processing element.
package mac_pkg;
  localparam int DEF_DATA_W  = 4;
  localparam int DEF_ACC_W   = 10;
  localparam int DEF_K_DEPTH = 4;
  localparam int CNT_W       = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;
endpackage

// File: rtl/mac_acc_unit.sv
// Multiply-accumulate datapath: next accumulator value from a*b and either zero or the running acc.
// Purely combinational; saturating add when SYSTOLIC_MAC_SATURATE_EN is defined.
module mac_acc_unit import mac_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ACC_W-1:0]  acc,
  input  logic              start,
  output logic [ACC_W-1:0]  acc_next
`ifdef SYSTOLIC_MAC_SATURATE_EN
  ,
  output logic              sat
`endif
);
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    base;

  assign prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
  // start drops the running value so the first beat of a product loads a*b alone
  assign base = start ? '0 : acc;

`ifdef SYSTOLIC_MAC_SATURATE_EN
  logic [ACC_W:0] wide;
  assign wide     = {1'b0, base} + (ACC_W+1)'(prod);
  assign sat      = wide[ACC_W];
  assign acc_next = sat ? '1 : wide[ACC_W-1:0];
`else
  assign acc_next = base + ACC_W'(prod);
`endif
endmodule

// File: rtl/systolic_mac_pe.sv
// Systolic MAC PE: K_DEPTH-beat dot product, 1-cycle a/b/valid forwards (SYSTOLIC_MAC_SATURATE_EN: saturate).
// Latency: sum/sum_valid one cycle after the completing beat; forwards one cycle.
// No backpressure: every in_valid beat is consumed; gaps stall the accumulation.
module systolic_mac_pe import mac_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int K_DEPTH = DEF_K_DEPTH
) (
  input  logic              clk,
  input  logic              res,
  input  logic              in_valid,
  input  logic              clear,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_valid,
  output logic [ACC_W-1:0]  sum,
  output logic              sum_valid,
  output logic              overflow
);
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(K_DEPTH);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count, count_nxt, beat_cnt;
  logic [ACC_W-1:0]   acc, acc_nxt, acc_sum;
  logic               start, done;

  // A clear alongside a beat makes that beat the first of a new product
  assign start    = (state == IDLE) || clear;
  assign beat_cnt = start ? CNT_W'(1) : count + CNT_W'(1);
  assign done     = in_valid && (beat_cnt == K_LAST);

`ifdef SYSTOLIC_MAC_SATURATE_EN
  logic sat;
`endif

  mac_acc_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_acc (
    .a        (a),
    .b        (b),
    .acc      (acc),
    .start    (start),
    .acc_next (acc_sum)
`ifdef SYSTOLIC_MAC_SATURATE_EN
    ,
    .sat      (sat)
`endif
  );

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    acc_nxt   = acc;
    if (in_valid) begin
      if (done) begin
        state_nxt = IDLE;
        count_nxt = '0;
        acc_nxt   = '0;
      end else begin
        state_nxt = ACCUM;
        count_nxt = beat_cnt;
        acc_nxt   = acc_sum;
      end
    end else if (clear) begin
      state_nxt = IDLE;
      count_nxt = '0;
      acc_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= IDLE;
      count <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      acc   <= acc_nxt;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      out_a     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      sum_valid <= 1'b0;
    end else begin
      out_a     <= a;
      out_b     <= b;
      out_valid <= in_valid;
      sum_valid <= done;
      if (done) sum <= acc_sum;
    end
  end

`ifdef SYSTOLIC_MAC_SATURATE_EN
  // Sticky per product; updates on the completing edge so it lines up with sum
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      overflow <= 1'b0;
    end else if (in_valid) begin
      overflow <= (start ? 1'b0 : overflow) | sat;
    end else if (clear) begin
      overflow <= 1'b0;
    end
  end
`else
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_systolic_mac_pe.sv
// Directed bench for systolic_mac_pe: three instances (default, ACC_W=8 wrap/saturate, K_DEPTH=1) with a scoreboard.
module tb_systolic_mac_pe;
  logic       clk, res, clear;
  logic [3:0] a, b;
  logic       v0, v1, v2;

  logic [3:0] oa0, ob0, oa1, ob1, oa2, ob2;
  logic       ov0_o, ov1_o, ov2_o;
  logic [9:0] s0, s2;
  logic [7:0] s1;
  logic       sv0, sv1, sv2, of0, of1, of2;

  int vectors = 0;
  int miscompares = 0;

  int q0[$];
  int q1[$];
  int q2[$];
  int m_acc[3];
  int m_cnt[3];
  int m_ovf[3];
  int kd[3] = '{4, 4, 1};
  int aw[3] = '{10, 8, 10};

  systolic_mac_pe u0 (
    .clk(clk), .res(res), .in_valid(v0), .clear(clear), .a(a), .b(b),
    .out_a(oa0), .out_b(ob0), .out_valid(ov0_o),
    .sum(s0), .sum_valid(sv0), .overflow(of0)
  );

  systolic_mac_pe #(.DATA_W(4), .ACC_W(8), .K_DEPTH(4)) u1 (
    .clk(clk), .res(res), .in_valid(v1), .clear(clear), .a(a), .b(b),
    .out_a(oa1), .out_b(ob1), .out_valid(ov1_o),
    .sum(s1), .sum_valid(sv1), .overflow(of1)
  );

  systolic_mac_pe #(.DATA_W(4), .ACC_W(10), .K_DEPTH(1)) u2 (
    .clk(clk), .res(res), .in_valid(v2), .clear(clear), .a(a), .b(b),
    .out_a(oa2), .out_b(ob2), .out_valid(ov2_o),
    .sum(s2), .sum_valid(sv2), .overflow(of2)
  );

  initial begin
    clk = 1'b0;
    #20;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset;
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0;
      m_cnt[i] = 0;
      m_ovf[i] = 0;
    end
  endtask

  // Drive one cycle of stimulus on instance inst and advance the reference model of all three
  task automatic beat(input int inst, input bit v, input bit clr, input int av, input int bv);
    int p, mx, e;
    a     = av[3:0];
    b     = bv[3:0];
    clear = clr;
    v0    = v && (inst == 0);
    v1    = v && (inst == 1);
    v2    = v && (inst == 2);
    for (int i = 0; i < 3; i++) begin
      if (v && i == inst) begin
        p  = av * bv;
        mx = (1 << aw[i]) - 1;
        if (clr || m_cnt[i] == 0) begin
          m_acc[i] = 0;
          m_cnt[i] = 0;
          m_ovf[i] = 0;
        end
`ifdef SYSTOLIC_MAC_SATURATE_EN
        if (m_acc[i] + p > mx) begin
          m_acc[i] = mx;
          m_ovf[i] = 1;
        end else begin
          m_acc[i] = m_acc[i] + p;
        end
`else
        m_acc[i] = (m_acc[i] + p) & mx;
`endif
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == kd[i]) begin
          e = (m_ovf[i] << 16) | m_acc[i];
          case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
          endcase
          m_acc[i] = 0;
          m_cnt[i] = 0;
        end
      end else if (clr) begin
        m_acc[i] = 0;
        m_cnt[i] = 0;
        m_ovf[i] = 0;
      end
    end
    cyc();
  endtask

  always @(negedge clk) begin
    if (sv0 === 1'b1) begin
      if (q0.size() == 0) chk("unexpected_pulse0", 32'd1, 32'd0);
      else chk("sb_sum0", {15'd0, of0, 6'd0, s0}, q0.pop_front());
    end
    if (sv1 === 1'b1) begin
      if (q1.size() == 0) chk("unexpected_pulse1", 32'd1, 32'd0);
      else chk("sb_sum1", {15'd0, of1, 8'd0, s1}, q1.pop_front());
    end
    if (sv2 === 1'b1) begin
      if (q2.size() == 0) chk("unexpected_pulse2", 32'd1, 32'd0);
      else chk("sb_sum2", {15'd0, of2, 6'd0, s2}, q2.pop_front());
    end
  end

  initial begin
    res = 1'b0; clear = 1'b0; a = '0; b = '0; v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    model_reset();
    #10 res = 1'b1;
    #2;
    chk("rst_out_a", 32'(oa0), 0);
    chk("rst_out_b", 32'(ob0), 0);
    chk("rst_out_valid", 32'(ov0_o), 0);
    chk("rst_sum", 32'(s0), 0);
    chk("rst_sum_valid", 32'(sv0), 0);
    chk("rst_overflow", 32'(of0), 0);
    chk("rst_sum1", 32'(s1), 0);
    chk("rst_sum_valid2", 32'(sv2), 0);
    #38 res = 1'b0;

    // Four-beat dot product: 6+1+16+0
    beat(0, 1, 0, 2, 3);
    beat(0, 1, 0, 1, 1);
    beat(0, 1, 0, 4, 4);
    chk("no_early_pulse", 32'(sv0), 0);
    beat(0, 1, 0, 0, 9);
    chk("dot_sum", 32'(s0), 23);
    chk("dot_pulse", 32'(sv0), 1);
    beat(0, 0, 0, 0, 0);
    chk("pulse_single", 32'(sv0), 0);
    chk("sum_hold", 32'(s0), 23);

    // Forwards, including while clear is asserted
    beat(0, 1, 0, 5, 7);
    chk("fwd_a", 32'(oa0), 5);
    chk("fwd_b", 32'(ob0), 7);
    chk("fwd_valid", 32'(ov0_o), 1);
    beat(0, 1, 1, 5, 7);
    chk("fwd_a_clr", 32'(oa0), 5);
    chk("fwd_valid_clr", 32'(ov0_o), 1);
    beat(0, 0, 1, 6, 2);
    chk("fwd_a_noval", 32'(oa0), 6);
    chk("fwd_valid_low", 32'(ov0_o), 0);
    chk("clr_keeps_sum", 32'(s0), 23);

    // Stall then clear-with-beat restarts the product
    beat(0, 1, 0, 2, 3);
    for (int i = 0; i < 3; i++) beat(0, 0, 0, 2, 3);
    beat(0, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) beat(0, 1, 0, 1, 1);
    chk("stall_clear_sum", 32'(s0), 4);
    chk("stall_clear_pulse", 32'(sv0), 1);

    // ACC_W=8: 4 x 225 wraps to 132, or saturates to 255
    for (int i = 0; i < 4; i++) beat(1, 1, 0, 15, 15);
`ifdef SYSTOLIC_MAC_SATURATE_EN
    chk("sat_sum", 32'(s1), 255);
    chk("sat_ovf", 32'(of1), 1);
`else
    chk("wrap_sum", 32'(s1), 132);
    chk("wrap_ovf", 32'(of1), 0);
`endif
    chk("wrap_pulse", 32'(sv1), 1);

    // K_DEPTH=1: back-to-back beats give back-to-back pulses
    beat(2, 1, 0, 3, 5);
    chk("k1_sum_a", 32'(s2), 15);
    chk("k1_pulse_a", 32'(sv2), 1);
    beat(2, 1, 0, 7, 2);
    chk("k1_sum_b", 32'(s2), 14);
    chk("k1_pulse_b", 32'(sv2), 1);
    beat(2, 1, 0, 15, 15);
    chk("k1_sum_c", 32'(s2), 225);
    beat(2, 0, 0, 0, 0);
    chk("k1_pulse_end", 32'(sv2), 0);

    // Reset mid-product discards the partial
    beat(0, 1, 0, 3, 3);
    beat(0, 1, 0, 2, 2);
    v0 = 1'b0;
    res = 1'b1;
    #1;
    chk("midrst_sum", 32'(s0), 0);
    chk("midrst_out_a", 32'(oa0), 0);
    chk("midrst_out_valid", 32'(ov0_o), 0);
    model_reset();
    cyc();
    res = 1'b0;
    for (int i = 0; i < 4; i++) beat(0, 1, 0, 1, 2);
    chk("post_rst_sum", 32'(s0), 8);
    beat(0, 0, 0, 0, 0);
    beat(0, 0, 0, 0, 0);

    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    chk("q2_drained", 32'(q2.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
